ps2_key_event_ctrl: RTL and testbench
=====================================

Name: ps2_key_event_ctrl

Overview:
Sequencer between the PS/2 byte receiver and the CPU bus. Consumes one-cycle byte strobes from the receiver and tracks E0 (extended) and F0 (break) prefix sequences with a prefix FSM. Assembles complete make/break key events and buffers them in a small show-ahead FIFO that the CPU pops through a memory-mapped read strobe. Flags overflow, bad frames and stalled prefix sequences.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
TIMEOUT_CYCLES, 1250000, CLK cycles a prefix state may wait for its next byte before abandoning (25 ms at 50 MHz).

Ports:
CLK  input  1  board clock; sole clock.
RESET  input  1  synchronous, active-high reset.
CODE_VALID  input  1  one-cycle strobe from receiver: CODE/CODE_ERR valid.
CODE  input  8  received scan byte.
CODE_ERR  input  1  frame/parity error on this byte.
RD_EN  input  1  CPU pop strobe, one entry per asserted cycle.
EVT_VALID  output  1  FIFO not empty.
EVT_DATA  output  10  head entry {released, extended, code[7:0]}.
EVT_COUNT  output  $clog2(DEPTH)+1  current occupancy.
OVERFLOW  output  1  sticky: event dropped because FIFO full.
OVF_CLR  input  1  clears OVERFLOW.
FRAME_ERR  output  1  one-cycle pulse per CODE_ERR byte.
PREFIX_TIMEOUT  output  1  one-cycle pulse when a prefix state times out.

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high, RESET.
- Reset: FSM to IDLE, pointers and count 0, timeout counter 0; EVT_VALID=0, EVT_DATA=0, EVT_COUNT=0, OVERFLOW=0, FRAME_ERR=0, PREFIX_TIMEOUT=0. Reset mid-sequence discards the prefix and all buffered events.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions happen only on CODE_VALID, except timeout.
- IDLE: E0 -> EXT; F0 -> BRK; 00 or FF (keyboard error/overrun) -> dropped, stay; any other byte -> push {0,0,code}.
- EXT: F0 -> EXT_BRK; E0 -> stay in EXT; 00/FF -> drop and go to IDLE; other -> push {0,1,code}, go to IDLE.
- BRK: E0 or F0 -> protocol error, drop and go to IDLE; other -> push {1,0,code}, go to IDLE.
- EXT_BRK: E0 or F0 -> drop and go to IDLE; other -> push {1,1,code}, go to IDLE.
- CODE_ERR=1 with CODE_VALID: byte ignored, FSM to IDLE from any state, FRAME_ERR pulses the next cycle.
- Timeout: counter cleared on every CODE_VALID and while in IDLE; increments in the other states. At TIMEOUT_CYCLES-1, FSM goes to IDLE and PREFIX_TIMEOUT pulses once.
- Latency: completing byte strobe at cycle n -> entry written at edge n+1. EVT_VALID/EVT_COUNT reflect it from cycle n+1.
- FIFO is show-ahead: EVT_DATA is the head entry, registered read-pointer mux. EVT_DATA holds its last value when empty (0 after reset).
- RD_EN while empty: ignored, no pointer change.
- Push while full without a pop: event dropped, OVERFLOW set.
- Push and pop in the same cycle: both execute, including when full. Count unchanged, no overflow.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from EVT_COUNT (0 and DEPTH).
- OVF_CLR and an overflowing push in the same cycle: set wins, OVERFLOW stays 1.

Test Plan:
- Byte 1C -> one entry {0,0,1C} (0x01C), EVT_VALID=1 next cycle, EVT_COUNT=1; RD_EN pulse -> EVT_COUNT=0, EVT_VALID=0.
- Bytes E0,F0,75 -> single entry 0x375. Bytes F0,72 -> 0x272. Bytes E0,6B -> 0x16B. Check FIFO order is preserved.
- Bytes E0, then no byte for TIMEOUT_CYCLES -> PREFIX_TIMEOUT pulses once. Following byte 75 -> 0x075, not 0x175.
- DEPTH=8: push 9 make codes (12,13..1A) with no reads -> EVT_COUNT=8, OVERFLOW=1, head=0x012, 1A lost. OVF_CLR -> OVERFLOW=0.
- FIFO full, byte 2A strobed with RD_EN in the same cycle -> count stays 8, OVERFLOW stays 0, new tail=0x02A.
- F0 then a byte with CODE_ERR=1 -> FRAME_ERR pulses, no entry, FSM in IDLE. RESET asserted mid-sequence after E0 -> all outputs return to 0 and the next byte 75 yields 0x075.

Source files
------------

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 key event sequencer: folds E0/F0 prefix bytes into make/break events
// and queues them in a show-ahead FIFO popped by the CPU.
module ps2_key_event_ctrl #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1250000
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     CODE_VALID,
  input  logic [7:0]               CODE,
  input  logic                     CODE_ERR,
  input  logic                     RD_EN,
  output logic                     EVT_VALID,
  output logic [9:0]               EVT_DATA,
  output logic [$clog2(DEPTH):0]   EVT_COUNT,
  output logic                     OVERFLOW,
  input  logic                     OVF_CLR,
  output logic                     FRAME_ERR,
  output logic                     PREFIX_TIMEOUT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t          state, state_next;
  logic [TW-1:0]   tmo_cnt;
  logic            timeout_hit;
  logic            push_req;
  logic [9:0]      push_data;
  logic            is_pfx, is_junk;

  logic [9:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_next;
  logic [CW-1:0]   count;
  logic            full, empty, do_push, do_pop, ovf_set;
  logic [9:0]      head_next;

  assign is_pfx  = (CODE == 8'hE0) || (CODE == 8'hF0);
  assign is_junk = (CODE == 8'h00) || (CODE == 8'hFF);

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (CODE_VALID) begin
      if (CODE_ERR) begin
        state_next = IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (CODE == 8'hE0)      state_next = EXT;
            else if (CODE == 8'hF0) state_next = BRK;
          end
          EXT: begin
            if (CODE == 8'hF0)      state_next = EXT_BRK;
            else if (CODE == 8'hE0) state_next = EXT;
            else                    state_next = IDLE;
          end
          BRK, EXT_BRK: state_next = IDLE;
          default:      state_next = IDLE;
        endcase
      end
    end else if (timeout_hit) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    timeout_hit = (state != IDLE) && !CODE_VALID && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    push_req    = 1'b0;
    push_data   = {2'b00, CODE};
    if (CODE_VALID && !CODE_ERR) begin
      unique case (state)
        IDLE:    push_req = !is_pfx && !is_junk;
        EXT: begin
          push_req  = !is_pfx && !is_junk;
          push_data = {2'b01, CODE};
        end
        BRK: begin
          push_req  = !is_pfx;
          push_data = {2'b10, CODE};
        end
        EXT_BRK: begin
          push_req  = !is_pfx;
          push_data = {2'b11, CODE};
        end
        default: push_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || CODE_VALID || state == IDLE || timeout_hit) tmo_cnt <= '0;
    else                                                    tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      FRAME_ERR      <= 1'b0;
      PREFIX_TIMEOUT <= 1'b0;
    end else begin
      FRAME_ERR      <= CODE_VALID && CODE_ERR;
      PREFIX_TIMEOUT <= timeout_hit;
    end
  end

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign do_pop      = RD_EN && !empty;
  assign do_push     = push_req && (!full || do_pop);
  assign ovf_set     = push_req && full && !do_pop;
  assign rd_ptr_next = rd_ptr + AW'(do_pop);

  // Head register looks one cycle ahead; a write into an otherwise empty
  // queue bypasses the memory so EVT_DATA is valid together with EVT_VALID.
  always_comb begin
    head_next = EVT_DATA;
    if ((count - CW'(do_pop)) == '0) begin
      if (do_push) head_next = push_data;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      EVT_DATA <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr   <= rd_ptr_next;
      EVT_DATA <= head_next;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (ovf_set)      OVERFLOW <= 1'b1;
      else if (OVF_CLR) OVERFLOW <= 1'b0;
    end
  end

  assign EVT_VALID = !empty;
  assign EVT_COUNT = count;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: vector table plus hand-written
// sequences for timeout, overflow, frame errors and mid-sequence reset.
module tb_ps2_key_event_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 16;

  logic       CLK = 1'b0;
  logic       RESET, CODE_VALID, CODE_ERR, RD_EN, OVF_CLR;
  logic [7:0] CODE;
  logic       EVT_VALID, OVERFLOW, FRAME_ERR, PREFIX_TIMEOUT;
  logic [9:0] EVT_DATA;
  logic [3:0] EVT_COUNT;

  int errors = 0;
  int checks = 0;

  ps2_key_event_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .CODE_VALID(CODE_VALID), .CODE(CODE),
    .CODE_ERR(CODE_ERR), .RD_EN(RD_EN), .EVT_VALID(EVT_VALID),
    .EVT_DATA(EVT_DATA), .EVT_COUNT(EVT_COUNT), .OVERFLOW(OVERFLOW),
    .OVF_CLR(OVF_CLR), .FRAME_ERR(FRAME_ERR), .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       v;
    logic [7:0] code;
    logic       rd;
    logic [3:0] cnt;
    logic [9:0] data;
  } vec_t;

  vec_t vecs[28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive for one rising edge, return at the next negedge.
  task automatic step(input logic v, input logic [7:0] c, input logic e,
                      input logic rd, input logic clr);
    CODE_VALID = v; CODE = c; CODE_ERR = e; RD_EN = rd; OVF_CLR = clr;
    @(negedge CLK);
    CODE_VALID = 1'b0; CODE = 8'h00; CODE_ERR = 1'b0; RD_EN = 1'b0; OVF_CLR = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    step(1'b1, c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int first, pulses;
    logic [7:0] b;

    vecs[0]  = '{1'b1, 8'h1C, 1'b0, 4'd1, 10'h01C};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 4'd0, 10'h01C};
    vecs[2]  = '{1'b1, 8'hE0, 1'b0, 4'd0, 10'h01C};
    vecs[3]  = '{1'b1, 8'hF0, 1'b0, 4'd0, 10'h01C};
    vecs[4]  = '{1'b1, 8'h75, 1'b0, 4'd1, 10'h375};
    vecs[5]  = '{1'b1, 8'hF0, 1'b0, 4'd1, 10'h375};
    vecs[6]  = '{1'b1, 8'h72, 1'b0, 4'd2, 10'h375};
    vecs[7]  = '{1'b1, 8'hE0, 1'b0, 4'd2, 10'h375};
    vecs[8]  = '{1'b1, 8'h6B, 1'b0, 4'd3, 10'h375};
    vecs[9]  = '{1'b1, 8'h00, 1'b0, 4'd3, 10'h375};
    vecs[10] = '{1'b1, 8'hFF, 1'b0, 4'd3, 10'h375};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 4'd2, 10'h272};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 4'd1, 10'h16B};
    vecs[13] = '{1'b1, 8'hF0, 1'b1, 4'd0, 10'h16B};
    vecs[14] = '{1'b1, 8'hE0, 1'b0, 4'd0, 10'h16B};
    vecs[15] = '{1'b1, 8'h29, 1'b0, 4'd1, 10'h029};
    vecs[16] = '{1'b1, 8'hE0, 1'b0, 4'd1, 10'h029};
    vecs[17] = '{1'b1, 8'hE0, 1'b0, 4'd1, 10'h029};
    vecs[18] = '{1'b1, 8'h00, 1'b0, 4'd1, 10'h029};
    vecs[19] = '{1'b1, 8'h11, 1'b0, 4'd2, 10'h029};
    vecs[20] = '{1'b0, 8'h00, 1'b1, 4'd1, 10'h011};
    vecs[21] = '{1'b1, 8'hE0, 1'b0, 4'd1, 10'h011};
    vecs[22] = '{1'b1, 8'hF0, 1'b0, 4'd1, 10'h011};
    vecs[23] = '{1'b1, 8'hF0, 1'b0, 4'd1, 10'h011};
    vecs[24] = '{1'b1, 8'h14, 1'b0, 4'd2, 10'h011};
    vecs[25] = '{1'b0, 8'h00, 1'b1, 4'd1, 10'h014};
    vecs[26] = '{1'b0, 8'h00, 1'b1, 4'd0, 10'h014};
    vecs[27] = '{1'b0, 8'h00, 1'b1, 4'd0, 10'h014};

    RESET = 1'b1; CODE_VALID = 1'b0; CODE = 8'h00; CODE_ERR = 1'b0;
    RD_EN = 1'b0; OVF_CLR = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    chk("rst_valid", 32'(EVT_VALID), 32'd0);
    chk("rst_data", 32'(EVT_DATA), 32'h0);
    chk("rst_count", 32'(EVT_COUNT), 32'd0);
    chk("rst_ovf", 32'(OVERFLOW), 32'd0);
    chk("rst_frame", 32'(FRAME_ERR), 32'd0);
    chk("rst_tmo", 32'(PREFIX_TIMEOUT), 32'd0);

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].code, 1'b0, vecs[i].rd, 1'b0);
      chk($sformatf("vec%0d_count", i), 32'(EVT_COUNT), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_valid", i), 32'(EVT_VALID), 32'(vecs[i].cnt != 0));
      chk($sformatf("vec%0d_data", i), 32'(EVT_DATA), 32'(vecs[i].data));
    end

    // Prefix timeout: E0 then silence; expect a single pulse TMO cycles later.
    send(8'hE0);
    first = 0; pulses = 0;
    for (int i = 1; i <= 3 * TMO; i++) begin
      idle();
      if (PREFIX_TIMEOUT) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    chk("tmo_pulse_cycle", 32'(first), 32'(TMO));
    chk("tmo_pulse_count", 32'(pulses), 32'd1);
    send(8'h75);
    chk("tmo_after_data", 32'(EVT_DATA), 32'h075);
    chk("tmo_after_count", 32'(EVT_COUNT), 32'd1);
    pop();
    chk("tmo_pop_count", 32'(EVT_COUNT), 32'd0);

    // Overflow: nine make codes into eight entries.
    for (int i = 0; i < 9; i++) begin
      b = 8'h12 + 8'(i);
      send(b);
    end
    chk("ovf_count", 32'(EVT_COUNT), 32'd8);
    chk("ovf_flag", 32'(OVERFLOW), 32'd1);
    chk("ovf_head", 32'(EVT_DATA), 32'h012);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(OVERFLOW), 32'd0);
    step(1'b1, 8'h2B, 1'b0, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(OVERFLOW), 32'd1);
    chk("ovf_set_count", 32'(EVT_COUNT), 32'd8);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr2", 32'(OVERFLOW), 32'd0);
    step(1'b1, 8'h2A, 1'b0, 1'b1, 1'b0);
    chk("full_pp_count", 32'(EVT_COUNT), 32'd8);
    chk("full_pp_ovf", 32'(OVERFLOW), 32'd0);
    chk("full_pp_head", 32'(EVT_DATA), 32'h013);
    for (int i = 0; i < 6; i++) begin
      pop();
      chk($sformatf("drain%0d_head", i), 32'(EVT_DATA), 32'h014 + 32'(i));
    end
    pop();
    chk("drain_tail", 32'(EVT_DATA), 32'h02A);
    chk("drain_tail_count", 32'(EVT_COUNT), 32'd1);
    pop();
    chk("drain_empty_valid", 32'(EVT_VALID), 32'd0);
    chk("drain_empty_hold", 32'(EVT_DATA), 32'h02A);

    // Frame error after F0: no entry, FSM back to IDLE.
    send(8'hF0);
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    chk("ferr_pulse", 32'(FRAME_ERR), 32'd1);
    chk("ferr_count", 32'(EVT_COUNT), 32'd0);
    idle();
    chk("ferr_one_cycle", 32'(FRAME_ERR), 32'd0);
    send(8'h44);
    chk("ferr_next_data", 32'(EVT_DATA), 32'h044);
    pop();

    // Reset mid-sequence with buffered events.
    send(8'h55);
    send(8'hE0);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("mrst_count", 32'(EVT_COUNT), 32'd0);
    chk("mrst_valid", 32'(EVT_VALID), 32'd0);
    chk("mrst_data", 32'(EVT_DATA), 32'h0);
    send(8'h75);
    chk("mrst_next_data", 32'(EVT_DATA), 32'h075);
    chk("mrst_next_count", 32'(EVT_COUNT), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
